// File: rtl/sd_cmd_engine.sv
// ---------------------------------------------------------------------------
// sd_cmd_engine
//
// SD host command-path controller. Takes one command at a time from the host
// register interface, frames it for the CMD-line PHY as {2'b01, index,
// argument}, waits for the PHY to accept the frame, then collects the
// response with a programmable timeout and automatic re-send on timeout.
// The response and status flags are returned to the host together with a
// one-cycle completion pulse. The host may abort a command at any point.
//
// Parameters
//   TIMEOUT_W  width of the timeout register and the response wait counter
//   MAX_RETRY  number of re-sends allowed after a response timeout
//   RETRY_W    width of the retry counter (must be able to hold MAX_RETRY)
//
// Ports
//   clock                rising-edge system clock
//   reset                synchronous, active-high reset
//   new_command          host request, only looked at while idle
//   abort                host cancel, highest priority while a command runs
//   cmd_index            command index (6 bits)
//   cmd_argument         command argument (32 bits)
//   rsp_type             0 NONE, 1 SHORT (index checked), 2 SHORT_NOCHK, 3 LONG
//   command_timeout_REG  response wait limit in cycles, 0 waits forever
//   ack_in               PHY has accepted the cmd_out frame
//   strobe_in            PHY response valid on cmd_in (single-cycle pulse)
//   cmd_in               raw 136-bit response frame from the PHY
//   busy                 a command is in progress
//   response             captured response payload
//   command_complete     one-cycle completion pulse
//   command_timeout      the final attempt timed out
//   command_index_error  SHORT response carried the wrong index
//   command_aborted      one-cycle pulse when an abort is taken
//   retry_count          re-sends used by the current command
//   strobe_out           cmd_out valid towards the PHY
//   ack_out              response consumed, towards the PHY
//   idle_out             engine is idle
//   cmd_out              outgoing 40-bit command frame
//
// Every output is driven straight from a register.
// ---------------------------------------------------------------------------
module sd_cmd_engine #(
    parameter int TIMEOUT_W = 32,
    parameter int MAX_RETRY = 2,
    parameter int RETRY_W   = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 new_command,
    input  logic                 abort,
    input  logic [5:0]           cmd_index,
    input  logic [31:0]          cmd_argument,
    input  logic [1:0]           rsp_type,
    input  logic [TIMEOUT_W-1:0] command_timeout_REG,
    input  logic                 ack_in,
    input  logic                 strobe_in,
    input  logic [135:0]         cmd_in,
    output logic                 busy,
    output logic [127:0]         response,
    output logic                 command_complete,
    output logic                 command_timeout,
    output logic                 command_index_error,
    output logic                 command_aborted,
    output logic [RETRY_W-1:0]   retry_count,
    output logic                 strobe_out,
    output logic                 ack_out,
    output logic                 idle_out,
    output logic [39:0]          cmd_out
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_SEND     = 2'd1;
    localparam logic [1:0] ST_WAIT_RSP = 2'd2;
    localparam logic [1:0] ST_DONE     = 2'd3;

    localparam logic [1:0] RSP_NONE        = 2'd0;
    localparam logic [1:0] RSP_SHORT       = 2'd1;
    localparam logic [1:0] RSP_SHORT_NOCHK = 2'd2;
    localparam logic [1:0] RSP_LONG        = 2'd3;

    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

    // Control state
    logic [1:0]           state_q,        state_d;
    logic [TIMEOUT_W-1:0] wait_cnt_q,     wait_cnt_d;
    logic [RETRY_W-1:0]   retry_q,        retry_d;

    // Command parameters latched when the command is accepted
    logic [5:0]           index_q,        index_d;
    logic [1:0]           type_q,         type_d;
    logic [TIMEOUT_W-1:0] timeout_q,      timeout_d;

    // Output registers
    logic                 busy_q,         busy_d;
    logic                 idle_q,         idle_d;
    logic [127:0]         response_q,     response_d;
    logic                 complete_q,     complete_d;
    logic                 timeout_flag_q, timeout_flag_d;
    logic                 idx_err_q,      idx_err_d;
    logic                 aborted_q,      aborted_d;
    logic                 strobe_out_q,   strobe_out_d;
    logic                 ack_out_q,      ack_out_d;
    logic [39:0]          cmd_out_q,      cmd_out_d;

    logic                 wait_expired;

    // Only the start/transmission bits, CRC and end bit of the raw frame are
    // never looked at; the PHY is responsible for them.
    logic                 unused_cmd_bits;
    assign unused_cmd_bits = ^{cmd_in[135:128], cmd_in[7:0]};

    // The wait counter starts at 0 on the first WAIT_RSP cycle, so reaching
    // timeout-1 at a clock edge means exactly "timeout" cycles have elapsed.
    // A zero timeout never expires.
    assign wait_expired = (timeout_q != '0) &&
                          (wait_cnt_q == timeout_q - TIMEOUT_W'(1));

    // Next-state logic. Pulsed outputs (complete, aborted, ack_out) default
    // low; everything else holds unless a transition changes it. Abort is
    // applied last so it overrides whatever the state case decided,
    // including a response arriving on the same edge.
    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        retry_d        = retry_q;
        index_d        = index_q;
        type_d         = type_q;
        timeout_d      = timeout_q;
        busy_d         = busy_q;
        idle_d         = idle_q;
        response_d     = response_q;
        complete_d     = 1'b0;
        timeout_flag_d = timeout_flag_q;
        idx_err_d      = idx_err_q;
        aborted_d      = 1'b0;
        strobe_out_d   = strobe_out_q;
        ack_out_d      = 1'b0;
        cmd_out_d      = cmd_out_q;

        case (state_q)
            ST_IDLE: begin
                if (new_command) begin
                    index_d        = cmd_index;
                    type_d         = rsp_type;
                    timeout_d      = command_timeout_REG;
                    response_d     = '0;
                    timeout_flag_d = 1'b0;
                    idx_err_d      = 1'b0;
                    retry_d        = '0;
                    wait_cnt_d     = '0;
                    cmd_out_d      = {2'b01, cmd_index, cmd_argument};
                    strobe_out_d   = 1'b1;
                    busy_d         = 1'b1;
                    idle_d         = 1'b0;
                    state_d        = ST_SEND;
                end
            end

            ST_SEND: begin
                if (ack_in) begin
                    strobe_out_d = 1'b0;
                    if (type_q == RSP_NONE) begin
                        complete_d = 1'b1;
                        state_d    = ST_DONE;
                    end else begin
                        wait_cnt_d = '0;
                        state_d    = ST_WAIT_RSP;
                    end
                end
            end

            ST_WAIT_RSP: begin
                if (timeout_q != '0) begin
                    wait_cnt_d = wait_cnt_q + TIMEOUT_W'(1);
                end
                // A response on the expiry edge still counts as a response.
                if (strobe_in) begin
                    case (type_q)
                        RSP_SHORT: begin
                            response_d = {96'd0, cmd_in[39:8]};
                            idx_err_d  = (cmd_in[45:40] != index_q);
                        end
                        RSP_SHORT_NOCHK: begin
                            response_d = {96'd0, cmd_in[39:8]};
                        end
                        RSP_LONG: begin
                            response_d = {8'd0, cmd_in[127:8]};
                        end
                        default: begin
                            response_d = response_q;
                        end
                    endcase
                    complete_d = 1'b1;
                    ack_out_d  = 1'b1;
                    state_d    = ST_DONE;
                end else if (wait_expired) begin
                    if (retry_q < RETRY_LIMIT) begin
                        // Re-send the same frame; cmd_out was never changed.
                        retry_d      = retry_q + RETRY_W'(1);
                        strobe_out_d = 1'b1;
                        state_d      = ST_SEND;
                    end else begin
                        timeout_flag_d = 1'b1;
                        complete_d     = 1'b1;
                        state_d        = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                busy_d  = 1'b0;
                idle_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort discards anything this edge would have captured and returns
        // straight to idle. It has no meaning while already idle.
        if (abort && (state_q != ST_IDLE)) begin
            state_d        = ST_IDLE;
            wait_cnt_d     = wait_cnt_q;
            retry_d        = retry_q;
            response_d     = response_q;
            timeout_flag_d = timeout_flag_q;
            idx_err_d      = idx_err_q;
            complete_d     = 1'b0;
            ack_out_d      = 1'b0;
            strobe_out_d   = 1'b0;
            aborted_d      = 1'b1;
            busy_d         = 1'b0;
            idle_d         = 1'b1;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            wait_cnt_q     <= '0;
            retry_q        <= '0;
            index_q        <= '0;
            type_q         <= RSP_NONE;
            timeout_q      <= '0;
            busy_q         <= 1'b0;
            idle_q         <= 1'b1;
            response_q     <= '0;
            complete_q     <= 1'b0;
            timeout_flag_q <= 1'b0;
            idx_err_q      <= 1'b0;
            aborted_q      <= 1'b0;
            strobe_out_q   <= 1'b0;
            ack_out_q      <= 1'b0;
            cmd_out_q      <= '0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            retry_q        <= retry_d;
            index_q        <= index_d;
            type_q         <= type_d;
            timeout_q      <= timeout_d;
            busy_q         <= busy_d;
            idle_q         <= idle_d;
            response_q     <= response_d;
            complete_q     <= complete_d;
            timeout_flag_q <= timeout_flag_d;
            idx_err_q      <= idx_err_d;
            aborted_q      <= aborted_d;
            strobe_out_q   <= strobe_out_d;
            ack_out_q      <= ack_out_d;
            cmd_out_q      <= cmd_out_d;
        end
    end

    assign busy                = busy_q;
    assign idle_out            = idle_q;
    assign response            = response_q;
    assign command_complete    = complete_q;
    assign command_timeout     = timeout_flag_q;
    assign command_index_error = idx_err_q;
    assign command_aborted     = aborted_q;
    assign retry_count         = retry_q;
    assign strobe_out          = strobe_out_q;
    assign ack_out             = ack_out_q;
    assign cmd_out             = cmd_out_q;

endmodule

// File: tb/tb_sd_cmd_engine.sv
// ---------------------------------------------------------------------------
// tb_sd_cmd_engine
//
// Self-checking bench for sd_cmd_engine. Each command pushes its expected
// outcome onto a queue when it is issued; a monitor pops and compares it
// when the engine signals completion or abort. The main flow plays the PHY
// side (ack_in, strobe_in, cmd_in) and checks timing-specific behaviour.
// ---------------------------------------------------------------------------
module tb_sd_cmd_engine;

    logic           clock;
    logic           reset;
    logic           new_command;
    logic           abort;
    logic [5:0]     cmd_index;
    logic [31:0]    cmd_argument;
    logic [1:0]     rsp_type;
    logic [31:0]    command_timeout_REG;
    logic           ack_in;
    logic           strobe_in;
    logic [135:0]   cmd_in;
    logic           busy;
    logic [127:0]   response;
    logic           command_complete;
    logic           command_timeout;
    logic           command_index_error;
    logic           command_aborted;
    logic [1:0]     retry_count;
    logic           strobe_out;
    logic           ack_out;
    logic           idle_out;
    logic [39:0]    cmd_out;

    sd_cmd_engine #(
        .TIMEOUT_W (32),
        .MAX_RETRY (2),
        .RETRY_W   (2)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .new_command         (new_command),
        .abort               (abort),
        .cmd_index           (cmd_index),
        .cmd_argument        (cmd_argument),
        .rsp_type            (rsp_type),
        .command_timeout_REG (command_timeout_REG),
        .ack_in              (ack_in),
        .strobe_in           (strobe_in),
        .cmd_in              (cmd_in),
        .busy                (busy),
        .response            (response),
        .command_complete    (command_complete),
        .command_timeout     (command_timeout),
        .command_index_error (command_index_error),
        .command_aborted     (command_aborted),
        .retry_count         (retry_count),
        .strobe_out          (strobe_out),
        .ack_out             (ack_out),
        .idle_out            (idle_out),
        .cmd_out             (cmd_out)
    );

    typedef struct {
        logic [127:0] rsp;
        logic         idxErr;
        logic         tmo;
        logic         ackOut;
        logic [1:0]   retries;
        logic         aborted;
    } expect_t;

    expect_t expQ[$];
    expect_t monExp;
    int      checksTotal  = 0;
    int      checksPassed = 0;
    int      completions  = 0;

    // Free-running clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single comparison point for every check in the bench
    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checksTotal++;
        if (observed === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Move to just after the next rising edge, where inputs are driven and
    // registered outputs are stable
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Issue one command for a single edge and record what it should produce
    task automatic applyStimulus(input logic [5:0] idx, input logic [31:0] arg,
                                 input logic [1:0] typ, input logic [31:0] tmo,
                                 input expect_t e);
        new_command         = 1'b1;
        cmd_index           = idx;
        cmd_argument        = arg;
        rsp_type            = typ;
        command_timeout_REG = tmo;
        expQ.push_back(e);
        step();
        new_command = 1'b0;
        checkOutput("acceptBusy", busy, 1);
        checkOutput("acceptStrobe", strobe_out, 1);
        checkOutput("acceptFrame", cmd_out, {2'b01, idx, arg});
    endtask

    task automatic ackSend();
        ack_in = 1'b1;
        step();
        ack_in = 1'b0;
    endtask

    task automatic sendResponse(input logic [135:0] frame);
        strobe_in = 1'b1;
        cmd_in    = frame;
        step();
        strobe_in = 1'b0;
    endtask

    // Bounded wait for the monitor to retire one scoreboard entry
    task automatic waitForEnd(input int budget);
        int start;
        start = completions;
        for (int i = 0; i < budget && completions == start; i++) step();
        if (completions == start) checkOutput("endWaitExpired", 0, 1);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "Busy"}, busy, 0);
        checkOutput({tag, "Idle"}, idle_out, 1);
        checkOutput({tag, "Response"}, response, 0);
        checkOutput({tag, "Complete"}, command_complete, 0);
        checkOutput({tag, "Timeout"}, command_timeout, 0);
        checkOutput({tag, "IdxErr"}, command_index_error, 0);
        checkOutput({tag, "Aborted"}, command_aborted, 0);
        checkOutput({tag, "Retry"}, retry_count, 0);
        checkOutput({tag, "StrobeOut"}, strobe_out, 0);
        checkOutput({tag, "AckOut"}, ack_out, 0);
        checkOutput({tag, "CmdOut"}, cmd_out, 0);
    endtask

    // Scoreboard monitor: sampled on the falling edge, well away from the
    // rising edge where the outputs change
    always @(negedge clock) begin
        if (!reset && (command_complete || command_aborted)) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedEnd", 1, 0);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("sbAborted", command_aborted, monExp.aborted);
                checkOutput("sbComplete", command_complete, !monExp.aborted);
                checkOutput("sbResponse", response, monExp.rsp);
                checkOutput("sbIdxErr", command_index_error, monExp.idxErr);
                checkOutput("sbTimeout", command_timeout, monExp.tmo);
                checkOutput("sbAckOut", ack_out, monExp.ackOut);
                checkOutput("sbRetry", retry_count, monExp.retries);
                checkOutput("sbBusy", busy, !monExp.aborted);
            end
            completions++;
        end
    end

    initial begin
        expect_t      e;
        logic [135:0] frame;
        logic [119:0] longBody;
        int           sends;
        int           waits;
        bit           done;
        logic [127:0] dummyRsp;

        reset               = 1'b1;
        new_command         = 1'b0;
        abort               = 1'b0;
        cmd_index           = '0;
        cmd_argument        = '0;
        rsp_type            = 2'd0;
        command_timeout_REG = '0;
        ack_in              = 1'b0;
        strobe_in           = 1'b0;
        cmd_in              = '0;

        waitCycles(2);
        checkResetValues("reset");
        reset = 1'b0;
        step();

        // NONE response, PHY acks two cycles after strobe_out rises
        $display("[TB] NONE command");
        e = '{rsp: '0, idxErr: 0, tmo: 0, ackOut: 0, retries: 0, aborted: 0};
        applyStimulus(6'd0, 32'h1234_5678, 2'd0, 32'd100, e);
        waitCycles(2);
        checkOutput("noneStillSending", strobe_out, 1);
        ackSend();
        checkOutput("noneCompleteNext", command_complete, 1);
        waitForEnd(4);
        checkOutput("noneIdleAfter", idle_out, 1);
        checkOutput("nonePulseOnce", command_complete, 0);

        // SHORT response with matching index
        $display("[TB] SHORT matching index");
        frame = '0;
        frame[45:40] = 6'd17;
        frame[39:8]  = 32'hDEAD_BEEF;
        frame[7:0]   = 8'hC3;
        e = '{rsp: 128'hDEAD_BEEF, idxErr: 0, tmo: 0, ackOut: 1, retries: 0, aborted: 0};
        applyStimulus(6'd17, 32'h0000_0001, 2'd1, 32'd100, e);
        ackSend();
        checkOutput("shortStrobeDrop", strobe_out, 0);
        waitCycles(3);
        sendResponse(frame);
        waitForEnd(4);

        // SHORT response with the wrong index
        $display("[TB] SHORT wrong index");
        frame[45:40] = 6'd5;
        e = '{rsp: 128'hDEAD_BEEF, idxErr: 1, tmo: 0, ackOut: 1, retries: 0, aborted: 0};
        applyStimulus(6'd17, 32'h0000_0002, 2'd1, 32'd100, e);
        ackSend();
        waitCycles(2);
        sendResponse(frame);
        waitForEnd(4);

        // LONG response: top byte of the response is forced to zero
        $display("[TB] LONG response");
        longBody = {8'hA5, 112'h0123456789ABCDEF_FEDCBA98_7654};
        frame    = {8'hFF, longBody, 8'h3C};
        e = '{rsp: {8'h00, longBody}, idxErr: 0, tmo: 0, ackOut: 1, retries: 0, aborted: 0};
        applyStimulus(6'd40, 32'hCAFE_F00D, 2'd3, 32'd100, e);
        ackSend();
        waitCycles(1);
        sendResponse(frame);
        waitForEnd(4);

        // Timeout of 10 with no response: three sends, 30 waiting cycles
        $display("[TB] SHORT timeout with retries");
        e = '{rsp: '0, idxErr: 0, tmo: 1, ackOut: 0, retries: 2'd2, aborted: 0};
        applyStimulus(6'd8, 32'h0000_00AA, 2'd1, 32'd10, e);
        sends = 0;
        waits = 0;
        done  = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (command_complete) begin
                done = 1;
            end else begin
                if (strobe_out) begin
                    sends++;
                    ack_in = 1'b1;
                end else begin
                    ack_in = 1'b0;
                    if (busy) waits++;
                end
                step();
            end
        end
        ack_in = 1'b0;
        checkOutput("retryDone", done, 1);
        checkOutput("retrySends", sends, 3);
        checkOutput("retryWaitCycles", waits, 30);
        waitForEnd(4);

        // Response on the 10th waiting cycle wins over expiry
        $display("[TB] response on expiry edge");
        frame = '0;
        frame[45:40] = 6'd8;
        frame[39:8]  = 32'h0BAD_F00D;
        e = '{rsp: 128'h0BAD_F00D, idxErr: 0, tmo: 0, ackOut: 1, retries: 0, aborted: 0};
        applyStimulus(6'd8, 32'h0000_00BB, 2'd1, 32'd10, e);
        ackSend();
        waitCycles(9);
        checkOutput("edgeNoResend", strobe_out, 0);
        sendResponse(frame);
        checkOutput("edgeComplete", command_complete, 1);
        waitForEnd(4);

        // Timeout of zero waits indefinitely; SHORT_NOCHK ignores the index
        $display("[TB] infinite wait");
        frame = '0;
        frame[45:40] = 6'd63;
        frame[39:8]  = 32'h5555_AAAA;
        e = '{rsp: 128'h5555_AAAA, idxErr: 0, tmo: 0, ackOut: 1, retries: 0, aborted: 0};
        applyStimulus(6'd2, 32'h0000_0003, 2'd2, 32'd0, e);
        ackSend();
        waitCycles(5000);
        checkOutput("foreverBusy", busy, 1);
        checkOutput("foreverNoTimeout", command_timeout, 0);
        checkOutput("foreverNoResend", strobe_out, 0);
        sendResponse(frame);
        waitForEnd(4);

        // Abort in WAIT_RSP on the same edge as a response
        $display("[TB] abort while waiting");
        frame = '0;
        frame[45:40] = 6'd11;
        frame[39:8]  = 32'h1111_2222;
        e = '{rsp: '0, idxErr: 0, tmo: 0, ackOut: 0, retries: 0, aborted: 1};
        applyStimulus(6'd11, 32'h0000_0004, 2'd1, 32'd50, e);
        ackSend();
        waitCycles(3);
        abort     = 1'b1;
        strobe_in = 1'b1;
        cmd_in    = frame;
        step();
        abort     = 1'b0;
        strobe_in = 1'b0;
        checkOutput("abortWaitIdle", idle_out, 1);
        checkOutput("abortWaitNoComplete", command_complete, 0);
        waitForEnd(4);
        checkOutput("abortWaitPulseOnce", command_aborted, 0);
        checkOutput("abortWaitNoLateComplete", command_complete, 0);

        // New command while busy is ignored, then abort in SEND
        $display("[TB] abort while sending");
        e = '{rsp: '0, idxErr: 0, tmo: 0, ackOut: 0, retries: 0, aborted: 1};
        applyStimulus(6'd12, 32'h0000_0005, 2'd1, 32'd50, e);
        new_command  = 1'b1;
        cmd_index    = 6'd9;
        cmd_argument = 32'hFFFF_0000;
        rsp_type     = 2'd0;
        step();
        new_command = 1'b0;
        checkOutput("busyIgnoreFrame", cmd_out, {2'b01, 6'd12, 32'h0000_0005});
        checkOutput("busyIgnoreStrobe", strobe_out, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        checkOutput("abortSendStrobe", strobe_out, 0);
        checkOutput("abortSendIdle", idle_out, 1);
        waitForEnd(4);

        // Reset in the middle of a retried wait
        $display("[TB] reset while waiting");
        e = '{rsp: '0, idxErr: 0, tmo: 0, ackOut: 0, retries: 0, aborted: 0};
        applyStimulus(6'd13, 32'h0000_0006, 2'd1, 32'd3, e);
        ackSend();
        waitCycles(3);
        checkOutput("midRetryCount", retry_count, 1);
        checkOutput("midResend", strobe_out, 1);
        ackSend();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        e = expQ.pop_back();
        dummyRsp = e.rsp;
        checkResetValues("midReset");
        step();

        checkOutput("queueEmpty", expQ.size(), 0);
        checkOutput("unusedRsp", dummyRsp, 0);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

    // Global guard so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL globalTimeout: observed running, expected finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule

// File: doc/sd_cmd_engine.md
# sd_cmd_engine

Parametrised SD host command-path controller between the host register interface and the CMD-line physical layer. It accepts one command at a time and frames it as start bits, index and argument. It then waits for the PHY to accept the frame, collects the response with a programmable timeout and automatic retry, and returns the response plus status flags to the host. The response type is an explicit host input, not decoded from the command index. The engine also supports host abort.

## Interface
Parameters:
- TIMEOUT_W, 32, width of timeout register and wait counter
- MAX_RETRY, 2, number of re-sends after a response timeout (0 = no retry)
- RETRY_W, 2, width of retry counter; must hold MAX_RETRY

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- new_command  in  1  request; sampled only in IDLE
- abort  in  1  cancel the current command; highest priority
- cmd_index  in  6  command index
- cmd_argument  in  32  command argument
- rsp_type  in  2  0 = NONE, 1 = SHORT (index checked), 2 = SHORT_NOCHK, 3 = LONG
- command_timeout_REG  in  TIMEOUT_W  response wait limit in cycles; 0 = wait forever
- ack_in  in  1  PHY accepted cmd_out frame
- strobe_in  in  1  PHY response valid on cmd_in (single-cycle pulse)
- cmd_in  in  136  raw response frame
- busy  out  1  command in progress
- response  out  128  captured response
- command_complete  out  1  one-cycle completion pulse
- command_timeout  out  1  final attempt timed out
- command_index_error  out  1  SHORT response index mismatch
- command_aborted  out  1  one-cycle pulse on abort
- retry_count  out  RETRY_W  re-sends used for the current command
- strobe_out  out  1  cmd_out valid to PHY
- ack_out  out  1  response consumed, to PHY
- idle_out  out  1  engine idle
- cmd_out  out  40  {2'b01, index, argument}

## Operation
- All outputs are registered.
- Reset values: busy=0, idle_out=1, all other outputs 0; state IDLE; counters 0.
- States: IDLE, SEND, WAIT_RSP, DONE.
- IDLE, on new_command:
  - latch index, argument, rsp_type and timeout;
  - clear response, error flags and retry_count;
  - load cmd_out; go to SEND.
- SEND:
  - strobe_out=1 and cmd_out held stable.
  - On ack_in: NONE goes to DONE; all other types go to WAIT_RSP with the wait counter cleared.
- WAIT_RSP:
  - strobe_out=0.
  - The counter increments every cycle while the latched timeout is nonzero.
  - On strobe_in:
    - SHORT: response[31:0]=cmd_in[39:8]; command_index_error=(cmd_in[45:40]!=latched index).
    - SHORT_NOCHK: response[31:0]=cmd_in[39:8]; no index check.
    - LONG: response[119:0]=cmd_in[127:8]; response[127:120]=0.
    - Go to DONE.
  - On expiry (counter == timeout-1 with no strobe_in at that edge):
    - if retry_count < MAX_RETRY: increment retry_count, go to SEND (cmd_out unchanged);
    - else: set command_timeout, go to DONE.
- DONE:
  - command_complete=1 for exactly one cycle.
  - ack_out=1 in the same cycle only if a response was captured.
  - Go to IDLE; busy falls and idle_out rises on that transition.
- Flags and response hold until the next accepted new_command.
- abort in SEND, WAIT_RSP or DONE:
  - next state IDLE; command_aborted pulses one cycle;
  - no command_complete; strobe_out and ack_out drop.
- abort in IDLE has no effect.

## Timing
- new_command accepted at edge N: busy=1 and strobe_out=1 from N+1.
- SEND to WAIT_RSP occurs at the edge where ack_in=1; strobe_out=0 the following cycle.
- A timeout of T cycles expires after exactly T cycles in WAIT_RSP.
- strobe_in on the expiry edge counts as a response, not a timeout.
- Response and flags are valid in the same cycle as command_complete.
- new_command while busy is ignored, with no queueing.
- reset mid-command returns to the reset values at the next edge.
- abort and strobe_in on the same edge: abort wins, no response is captured.

## Test plan
- Index 0, rsp_type NONE, ack_in 2 cycles after strobe_out -> command_complete one cycle later, ack_out=0, response=0.
- Index 17, SHORT, cmd_in[45:40]=17, cmd_in[39:8]=32'hDEADBEEF -> response=32'hDEADBEEF, index_error=0, ack_out=1; repeat with cmd_in[45:40]=5 -> index_error=1.
- LONG, cmd_in[127:8]=120'hA5... -> response[119:0] matches, [127:120]=0, no index check.
- SHORT, timeout=10, MAX_RETRY=2, no strobe_in -> three SEND phases, retry_count=2, command_timeout=1 after 3×10 WAIT_RSP cycles; strobe_in on cycle 10 of the first wait -> no retry, no timeout.
- Timeout=0, strobe_in after 5000 cycles -> normal completion, no timeout.
- abort during WAIT_RSP and during SEND -> command_aborted pulse, IDLE next cycle, no command_complete; new_command while busy is ignored; reset mid-WAIT_RSP -> all outputs at reset values next cycle.
